// File: rtl/fpaddsub_seq.sv
// rtl/fpaddsub_seq.sv - multi-cycle handshaked binary32 add/subtract; define FPADDSUB_RNE_EN for round-to-nearest-even (default truncate)
module fpaddsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [2:0]  flags
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [31:0]       ra, rb;          // captured operands, rb already sign-flipped for subtract
    logic              sgn_l, sgn_s;    // signs of larger / smaller magnitude operand
    logic [7:0]        exp_l;
    logic [26:0]       man_l, man_s;    // 24-bit significand + guard, round, sticky
    logic [27:0]       sum;
    logic              sgn_r;
    logic signed [9:0] exp_r;
    logic [26:0]       man_n;
    logic              flushed;
    logic              spec, spec_inv;
    logic [31:0]       spec_val;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i <= 26; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    // ALIGN: unpack, flush denormals, order by magnitude, shift smaller into the GRS field
    logic [7:0]  ea, eb, dexp;
    logic [30:0] mag_a, mag_b;
    logic [26:0] fa, fb, fsmall, lost_mask, shifted;
    logic        swap, nan_a, nan_b, inf_a, inf_b;
    logic [31:0] spec_val_nx;
    logic        spec_inv_nx;
    always_comb begin
        ea        = ra[30:23];
        eb        = rb[30:23];
        mag_a     = (ea == 8'd0) ? 31'd0 : ra[30:0];
        mag_b     = (eb == 8'd0) ? 31'd0 : rb[30:0];
        fa        = (ea == 8'd0) ? 27'd0 : {1'b1, ra[22:0], 3'b000};
        fb        = (eb == 8'd0) ? 27'd0 : {1'b1, rb[22:0], 3'b000};
        swap      = mag_b > mag_a;
        dexp      = swap ? (eb - ea) : (ea - eb);
        fsmall    = swap ? fa : fb;
        lost_mask = (27'd1 << dexp[4:0]) - 27'd1;
        if (dexp >= 8'd27)
            shifted = {26'd0, |fsmall};
        else
            shifted = (fsmall >> dexp) | {26'd0, |(fsmall & lost_mask)};
        nan_a = (ea == 8'hFF) && (ra[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (rb[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (ra[22:0] == 23'd0);
        inf_b = (eb == 8'hFF) && (rb[22:0] == 23'd0);
        spec_inv_nx = 1'b0;
        if (nan_a || nan_b)
            spec_val_nx = 32'h7FC00000;
        else if (inf_a && inf_b && (ra[31] != rb[31])) begin
            spec_val_nx = 32'h7FC00000;
            spec_inv_nx = 1'b1;
        end else if (inf_a)
            spec_val_nx = {ra[31], 8'hFF, 23'd0};
        else
            spec_val_nx = {rb[31], 8'hFF, 23'd0};
    end

    // ADD: magnitude add or subtract; larger-minus-smaller never goes negative
    logic [27:0] sum_nx;
    logic        sgn_r_nx;
    always_comb begin
        if (sgn_l == sgn_s)
            sum_nx = {1'b0, man_l} + {1'b0, man_s};
        else
            sum_nx = {1'b0, man_l} - {1'b0, man_s};
        sgn_r_nx = (sgn_l != sgn_s && sum_nx == 28'd0) ? 1'b0 : sgn_l;
    end

    // NORM: bring the leading one to bit 26, flush anything that lands at or below exponent zero
    logic [4:0]        lz;
    logic [26:0]       man_n_nx;
    logic signed [9:0] exp_n_nx;
    logic              flushed_nx;
    always_comb begin
        lz         = lzc27(sum[26:0]);
        flushed_nx = 1'b0;
        if (sum[27]) begin
            man_n_nx = {sum[27:2], sum[1] | sum[0]};
            exp_n_nx = $signed({2'b00, exp_l}) + 10'sd1;
        end else if (sum[26:0] == 27'd0) begin
            man_n_nx = 27'd0;
            exp_n_nx = 10'sd0;
        end else begin
            man_n_nx = sum[26:0] << lz;
            exp_n_nx = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
            if (exp_n_nx <= 10'sd0) begin
                man_n_nx   = 27'd0;
                exp_n_nx   = 10'sd0;
                flushed_nx = 1'b1;
            end
        end
    end

    // ROUND: a rounding carry out of the fraction ripples straight into the exponent field
    logic        inc;
    logic [30:0] mag_rnd;
    logic [31:0] out_nx;
    logic [2:0]  flags_nx;
    always_comb begin
`ifdef FPADDSUB_RNE_EN
        inc = man_n[2] & (man_n[1] | man_n[0] | man_n[3]);
`else
        inc = 1'b0;
`endif
        mag_rnd = {exp_r[7:0], man_n[25:3]} + {30'd0, inc};
        if (spec) begin
            out_nx   = spec_val;
            flags_nx = {spec_inv, 2'b00};
        end else if (man_n == 27'd0) begin
            out_nx   = {sgn_r, 31'd0};
            flags_nx = {2'b00, flushed};
        end else if (exp_r >= 10'sd255 || mag_rnd[30:23] == 8'hFF) begin
            out_nx   = {sgn_r, 8'hFF, 23'd0};
            flags_nx = 3'b011;
        end else begin
            out_nx   = {sgn_r, mag_rnd};
            flags_nx = {2'b00, |man_n[2:0]};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state: one fixed walk per operation, DONE waits for the consumer
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // Datapath registers; DONE spends its first cycle publishing the result before raising out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0; rb <= '0;
            sgn_l <= 1'b0; sgn_s <= 1'b0; exp_l <= '0; man_l <= '0; man_s <= '0;
            spec <= 1'b0; spec_inv <= 1'b0; spec_val <= '0;
            sum <= '0; sgn_r <= 1'b0; exp_r <= '0; man_n <= '0; flushed <= 1'b0;
            out <= '0; flags <= '0; out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra <= a;
                    rb <= b ^ {op, 31'd0};
                end
                ALIGN: begin
                    sgn_l    <= swap ? rb[31] : ra[31];
                    sgn_s    <= swap ? ra[31] : rb[31];
                    exp_l    <= swap ? eb : ea;
                    man_l    <= swap ? fb : fa;
                    man_s    <= shifted;
                    spec     <= nan_a | nan_b | inf_a | inf_b;
                    spec_val <= spec_val_nx;
                    spec_inv <= spec_inv_nx;
                end
                ADD: begin
                    sum   <= sum_nx;
                    sgn_r <= sgn_r_nx;
                end
                NORM: begin
                    man_n   <= man_n_nx;
                    exp_r   <= exp_n_nx;
                    flushed <= flushed_nx;
                end
                ROUND: begin
                    out   <= out_nx;
                    flags <= flags_nx;
                end
                DONE: begin
                    if (!out_valid)
                        out_valid <= 1'b1;
                    else if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpaddsub_seq.sv
// tb/tb_fpaddsub_seq.sv - self-checking bench for fpaddsub_seq (directed plus randomized against an exact-arithmetic model)
module tb_fpaddsub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic [2:0]  flags;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    fpaddsub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact sum of the two values as big integers, then rounded once to binary32.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f);
        logic [7:0]          ex, ey;
        logic                zx, zy, sg, inc;
        logic [129:0]        vx, vy, mag, rem, half, mant;
        logic signed [130:0] tx, ty, s;
        int                  base, p, e, sh;
        ex = x[30:23];
        ey = y[30:23];
        f  = 3'b000;
        if ((ex == 8'hFF && x[22:0] != 0) || (ey == 8'hFF && y[22:0] != 0)) begin
            r = 32'h7FC00000; return;
        end
        if (ex == 8'hFF && ey == 8'hFF && x[31] != y[31]) begin
            r = 32'h7FC00000; f = 3'b100; return;
        end
        if (ex == 8'hFF) begin r = {x[31], 8'hFF, 23'd0}; return; end
        if (ey == 8'hFF) begin r = {y[31], 8'hFF, 23'd0}; return; end
        zx = (ex == 8'd0);
        zy = (ey == 8'd0);
        if (zx && zy) begin r = {x[31] & y[31], 31'd0}; return; end
        base = zx ? int'(ey) : zy ? int'(ex) : (ex < ey ? int'(ex) : int'(ey));
        vx = zx ? '0 : ({106'd0, 1'b1, x[22:0]} << (int'(ex) - base));
        vy = zy ? '0 : ({106'd0, 1'b1, y[22:0]} << (int'(ey) - base));
        tx = {1'b0, vx}; if (x[31]) tx = -tx;
        ty = {1'b0, vy}; if (y[31]) ty = -ty;
        s   = tx + ty;
        sg  = s[130];
        mag = 130'(sg ? -s : s);
        if (mag == 0) begin r = {x[31] & y[31], 31'd0}; return; end
        p = 0;
        for (int i = 0; i < 130; i++) if (mag[i]) p = i;
        e = base + p - 23;
        if (e <= 0) begin r = {sg, 31'd0}; f = 3'b001; return; end
        if (p > 23) begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((130'd1 << sh) - 130'd1);
            half = 130'd1 << (sh - 1);
        end else begin
            mant = mag << (23 - p);
            rem  = '0;
            half = 130'd1;
        end
`ifdef FPADDSUB_RNE_EN
        inc = (rem > half) || (rem == half && mant[0]);
`else
        inc = 1'b0;
`endif
        mant = mant + {129'd0, inc};
        if (mant[24]) begin mant = mant >> 1; e++; end
        if (e >= 255) begin r = {sg, 8'hFF, 23'd0}; f = 3'b011; return; end
        r = {sg, 8'(e), mant[22:0]};
        f = {2'b00, rem != 0};
    endfunction

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic top, input logic [31:0] er, input logic [2:0] ef);
        int lat;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " out"}, out, er);
        check({tag, " flags"}, 32'(flags), 32'(ef));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] er, hold_out, exp_rne;
        logic [2:0]  ef, hold_flags;
        int          lat, seen, bad_out, bad_rdy;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", out, 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-operation discards the in-flight op
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1; end
        check("midrst no result", 32'(seen), 32'd0);
        check("midrst in_ready after", 32'(in_ready), 32'd1);
        check("midrst out", out, 32'd0);

        do_op("1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        do_op("1.5+2.25", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000);
        do_op("1-1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        do_op("inf-inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        do_op("max+max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        do_op("nan", 32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        do_op("-inf+fin", 32'hFF800000, 32'h42000000, 1'b1, 32'hFF800000, 3'b000);
        do_op("denorm flush", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        do_op("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
`ifdef FPADDSUB_RNE_EN
        exp_rne = 32'h3F800001;
`else
        exp_rne = 32'h3F800000;
`endif
        do_op("1+tiny", 32'h3F800000, 32'h33C00000, 1'b0, exp_rne, 3'b001);
`ifdef FPADDSUB_RNE_EN
        exp_rne = 32'h3F800000;
`else
        exp_rne = 32'h3F7FFFFF;
`endif
        do_op("1-sticky", 32'h3F800000, 32'h2F800000, 1'b1, exp_rne, 3'b001);

        // Backpressure: result held, second request waits until after the handshake
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h40100000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("bp latency", 32'(lat), 32'd5);
        check("bp out", out, 32'h40700000);
        hold_out = out; hold_flags = flags;
        bad_out = 0; bad_rdy = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out !== 32'h40700000 || flags !== 3'b000 || out_valid !== 1'b1) bad_out++;
            if (in_ready !== 1'b0) bad_rdy++;
        end
        check("bp out stable", 32'(bad_out), 32'd0);
        check("bp in_ready low", 32'(bad_rdy), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp in_ready after hs", 32'(in_ready), 32'd1);
        check("bp out_valid after hs", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp second accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("bp2 latency", 32'(lat), 32'd5);
        check("bp2 out", out, 32'h00000000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized operands against the exact-arithmetic model
        for (int i = 0; i < 40; i++) begin
            int          e1, e2;
            logic [31:0] x, y;
            logic        o;
            e1 = (i % 2 == 0) ? int'($urandom_range(30, 1)) : int'($urandom_range(254, 1));
            e2 = e1 + int'($urandom_range(80, 0)) - 40;
            if (e2 < 1) e2 = 1;
            if (e2 > 254) e2 = 254;
            if ($urandom_range(7, 0) == 0) e2 = 0;
            x = {1'($urandom), 8'(e1), 23'($urandom)};
            y = {1'($urandom), 8'(e2), 23'($urandom)};
            o = 1'($urandom);
            if ($urandom_range(7, 0) == 0) begin y = x; o = 1'b1; end
            model(x, y ^ {o, 31'd0}, er, ef);
            do_op($sformatf("rnd%0d", i), x, y, o, er, ef);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
